// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the MMIO UART.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with the head word visible combinationally on dout.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped internally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart.sv
// 8N1 UART on the MMIO port: TX FIFO + serialiser, RX deserialiser + one-byte holding register.
// Latency: MMIO handshakes are zero-latency (combinational); TX line starts one cycle after push.
// Backpressure: TXDATA writes stall (wr_ready=0) while the TX FIFO is full; other offsets never stall.
module mmio_uart
  import uart_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'hFFFF0000,
  parameter int          CLKS_PER_BIT  = 868,
  parameter int          TX_FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_mmio_addr,
  output logic [DATA_WIDTH-1:0] o_mmio_data,
  output logic                  o_mmio_rd_valid,
  input  logic                  i_mmio_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_mmio_data,
  input  logic                  i_mmio_wr_valid,
  output logic                  o_mmio_wr_ready,
  output logic                  o_tx,
  input  logic                  i_rx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       hit;
  logic [1:0] offset;
  logic [4:0] status;
  logic       rx_pop;
  logic       status_clr;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       tx_empty;

  uart_state_t   tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_idx, tx_idx_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic          tx_line, tx_line_d;

  logic          rx_meta, rx_sync;
  uart_state_t   rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_idx, rx_idx_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic          rx_deliver;
  logic          rx_stop_bad;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_overrun;
  logic       rx_frame_err;

  // Upper write-data bits and the byte lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{i_mmio_addr[1:0], i_mmio_data[DATA_WIDTH-1:8]};

  assign hit      = (i_mmio_addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = i_mmio_addr[3:2];
  assign tx_empty = fifo_empty && (tx_state == IDLE);
  assign o_tx     = tx_line;

  // STATUS word assembly.
  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = fifo_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_VALID]     = rx_valid;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
  end

  // Read mux and ready decode; every output collapses to zero on an address miss.
  always_comb begin
    o_mmio_data     = '0;
    o_mmio_rd_valid = hit;
    o_mmio_wr_ready = hit;
    if (hit) begin
      case (offset)
        REG_TXDATA: o_mmio_wr_ready = !fifo_full;
        REG_RXDATA: o_mmio_data[8:0] = {rx_valid, rx_byte};
        REG_STATUS: o_mmio_data[4:0] = status;
        default:    ;
      endcase
    end
  end

  assign fifo_push  = i_mmio_wr_valid && o_mmio_wr_ready && (offset == REG_TXDATA);
  assign status_clr = i_mmio_wr_valid && o_mmio_wr_ready && (offset == REG_STATUS);
  assign rx_pop     = o_mmio_rd_valid && i_mmio_rd_ready && (offset == REG_RXDATA) && rx_valid;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (i_mmio_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX next-state: STOP chains straight into START when another byte is queued.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    fifo_pop   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = DATA;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx == 3'd7) tx_state_d = STOP;
          else                tx_idx_d   = tx_idx + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    // The line is registered from the next state so it changes exactly on the bit edge.
    case (tx_state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = tx_shift_d[tx_idx_d];
      default: tx_line_d = 1'b1;
    endcase
  end

  // TX state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  // Two-flop synchronizer on the asynchronous RX pin, idling high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // RX next-state: sample mid-bit; a start bit that is high at mid-bit is a glitch.
  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_idx_d    = rx_idx;
    rx_shift_d  = rx_shift;
    rx_deliver  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_sync) begin
          rx_cnt_d   = '0;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_state_d = rx_sync ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          if (rx_idx == 3'd7) rx_state_d = STOP;
          else                rx_idx_d   = rx_idx + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d    = '0;
          rx_deliver  = 1'b1;
          rx_stop_bad = !rx_sync;
          rx_state_d  = IDLE;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_idx   <= rx_idx_d;
      rx_shift <= rx_shift_d;
    end
  end

  // Holding register and sticky flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_deliver && (!rx_valid || rx_pop)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end

      if (rx_deliver && rx_valid && !rx_pop)     rx_overrun <= 1'b1;
      else if (status_clr && i_mmio_data[3])     rx_overrun <= 1'b0;

      if (rx_deliver && rx_stop_bad)             rx_frame_err <= 1'b1;
      else if (status_clr && i_mmio_data[4])     rx_frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed + randomized bench for mmio_uart with a behavioural UART/register model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mmio_uart;

  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        tx;
  logic        rx = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart #(
    .DATA_WIDTH    (32),
    .BASE_ADDR     (BASE),
    .CLKS_PER_BIT  (CPB),
    .TX_FIFO_DEPTH (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_mmio_addr     (addr),
    .o_mmio_data     (rdat),
    .o_mmio_rd_valid (rd_valid),
    .i_mmio_rd_ready (rd_ready),
    .i_mmio_data     (wdat),
    .i_mmio_wr_valid (wr_valid),
    .o_mmio_wr_ready (wr_ready),
    .o_tx            (tx),
    .i_rx            (rx)
  );

  // Line monitor: decodes o_tx like a remote UART, recording frame start cycles.
  logic [9:0] tx_q [$];
  int         fall_q [$];
  logic [9:0] mon_bits;
  int         mon_t;
  bit         mon_busy = 1'b0;
  logic       prev_tx  = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      prev_tx  = 1'b1;
    end else begin
      if (!mon_busy && prev_tx && !tx) begin
        mon_busy = 1'b1;
        mon_t    = 0;
        fall_q.push_back(cyc);
      end
      if (mon_busy) begin
        if (mon_t % CPB == CPB / 2) mon_bits[mon_t / CPB] = tx;
        mon_t++;
        if (mon_t == 9 * CPB + CPB / 2 + 1) begin
          mon_busy = 1'b0;
          tx_q.push_back(mon_bits);
        end
      end
      prev_tx = tx;
    end
  end

  // Reference model of the RX holding register and sticky flags.
  logic       m_valid = 1'b0;
  logic [7:0] m_byte  = '0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;

  function automatic void m_rx(input logic [7:0] b, input logic stop_bit);
    if (!m_valid) begin
      m_byte  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
    if (!stop_bit) m_ferr = 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    return {27'b0, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
  endfunction

  function automatic logic [31:0] m_rxdata_pop();
    logic [31:0] r;
    r = {23'b0, m_valid, m_byte};
    m_valid = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d, output int waited);
    addr     = a;
    wdat     = d;
    wr_valid = 1'b1;
    waited   = 0;
    #1;
    while (!wr_ready && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!wr_ready) check("wr_timeout", {31'b0, wr_ready}, 32'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    addr     = a;
    rd_ready = 1'b1;
    #1;
    d = rdat;
    v = rd_valid;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) tick();
    end
    rx = 1'b1;
    repeat (2 * CPB) tick();
    m_rx(b, stop_bit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int          w;
    int          bad;
    int          n;
    logic [7:0]  b;
    logic        sb;
    logic [7:0]  bytes [6];
    logic [9:0]  frame;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_tx", {31'b0, tx}, 32'd1);
    mmio_read(BASE + 32'h8, d, v);
    check("rst_status", d, 32'h2);
    check("rst_status_vld", {31'b0, v}, 32'd1);
    mmio_read(BASE + 32'h4, d, v);
    check("rst_rxdata", d, 32'h0);

    // Single byte 0x55: exact waveform, 10 bit periods.
    mmio_write(BASE, 32'h55, w);
    check("tx55_wr_ready", w, 0);
    check("tx55_idle_before_start", {31'b0, tx}, 32'd1);
    tick();
    frame = {1'b1, 8'h55, 1'b0};
    bad = 0;
    for (int t = 0; t < 10 * CPB; t++) begin
      if (tx !== frame[t / CPB]) bad++;
      tick();
    end
    check("tx55_wave_bad_cycles", bad, 0);
    mmio_read(BASE + 32'h8, d, v);
    check("tx55_status_after", d, 32'h2);

    // Back-to-back frames and FIFO backpressure.
    tx_q.delete();
    fall_q.delete();
    for (int k = 0; k < 5; k++) begin
      bytes[k] = 8'($urandom);
      mmio_write(BASE, {24'b0, bytes[k]}, w);
      check("b2b_wr_ready", w, 0);
    end
    bytes[5] = 8'($urandom);
    mmio_write(BASE | 32'h1, {24'b0, bytes[5]}, w);
    check("b2b_backpressure_cycles", w, 77);
    n = 0;
    while (tx_q.size() < 6 && n < 1000) begin
      tick();
      n++;
    end
    check("b2b_frame_count", tx_q.size(), 6);
    for (int k = 0; k < tx_q.size() && k < 6; k++)
      check("b2b_frame_bits", {22'b0, tx_q[k]}, {22'b0, 1'b1, bytes[k], 1'b0});
    for (int k = 1; k < fall_q.size(); k++)
      check("b2b_frame_spacing", fall_q[k] - fall_q[k-1], 10 * CPB);
    repeat (2 * CPB) tick();
    mmio_read(BASE + 32'h8, d, v);
    check("b2b_status_after", d, 32'h2);

    // RX 0xA3, then pop and re-read.
    send_rx(8'hA3, 1'b1);
    mmio_read(BASE + 32'h8, d, v);
    check("rxA3_status", d, m_status());
    mmio_read(BASE + 32'h4, d, v);
    check("rxA3_rxdata", d, m_rxdata_pop());
    mmio_read(BASE + 32'h4, d, v);
    check("rxA3_rxdata_again", d, m_rxdata_pop());

    // Overrun and write-1-to-clear.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    mmio_read(BASE + 32'h8, d, v);
    check("ovr_status", d, m_status());
    mmio_read(BASE + 32'h4, d, v);
    check("ovr_rxdata", d, m_rxdata_pop());
    mmio_write(BASE + 32'h8, 32'h8, w);
    m_ovr = 1'b0;
    mmio_read(BASE + 32'h8, d, v);
    check("ovr_cleared_status", d, m_status());

    // Framing error: byte still delivered.
    b = 8'($urandom);
    send_rx(b, 1'b0);
    mmio_read(BASE + 32'h8, d, v);
    check("ferr_status", d, m_status());
    mmio_read(BASE + 32'h4, d, v);
    check("ferr_rxdata", d, m_rxdata_pop());
    mmio_write(BASE + 32'h8, 32'h10, w);
    m_ferr = 1'b0;
    mmio_read(BASE + 32'h8, d, v);
    check("ferr_cleared_status", d, m_status());

    // Short glitch is rejected and the receiver still works afterwards.
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    mmio_read(BASE + 32'h8, d, v);
    check("glitch_status", d, m_status());
    b = 8'($urandom);
    send_rx(b, 1'b1);
    mmio_read(BASE + 32'h4, d, v);
    check("post_glitch_rxdata", d, m_rxdata_pop());

    // Randomized RX traffic with optional reads.
    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(3) != 0);
      send_rx(b, sb);
      if ($urandom_range(1) == 1) begin
        mmio_read(BASE + 32'h4, d, v);
        check("rand_rxdata", d, m_rxdata_pop());
      end
      mmio_read(BASE + 32'h8, d, v);
      check("rand_status", d, m_status());
      mmio_write(BASE + 32'h8, 32'h18, w);
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
    mmio_read(BASE + 32'h4, d, v);
    check("rand_final_rxdata", d, m_rxdata_pop());

    // Decode: miss and the unused offsets.
    mmio_read(BASE + 32'h10, d, v);
    check("miss_rd_valid", {31'b0, v}, 32'd0);
    check("miss_rd_data", d, 32'h0);
    addr     = BASE + 32'h10;
    wr_valid = 1'b1;
    #1;
    check("miss_wr_ready", {31'b0, wr_ready}, 32'd0);
    wr_valid = 1'b0;
    tick();
    mmio_read(BASE + 32'hC, d, v);
    check("off3_rd", {v, d[30:0]}, 32'h8000_0000);
    mmio_read(BASE, d, v);
    check("txdata_rd", {v, d[30:0]}, 32'h8000_0000);
    mmio_write(BASE + 32'hC, 32'hFF, w);
    check("off3_wr_ready", w, 0);
    mmio_read(BASE + 32'h8, d, v);
    check("off3_wr_no_effect", d, 32'h2);

    // Reset in the middle of a frame discards the frame and the queued bytes.
    mmio_write(BASE, 32'h00, w);
    mmio_write(BASE, 32'h5A, w);
    mmio_write(BASE, 32'hC3, w);
    repeat (20) tick();
    check("midrst_line_low", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_tx_high", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    mmio_read(BASE + 32'h8, d, v);
    check("midrst_status", d, m_status());
    bad = 0;
    repeat (200) begin
      if (!tx) bad++;
      tick();
    end
    check("midrst_fifo_discarded", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
